l2_mem_arbiter: RTL

- Shares the single 128-bit line-wide external memory port between two L2 cache instances: instruction-side (port I) and data-side (port D).
- Each port presents the same interface an L2 cache drives toward memory: read/write/addr/wdata in, rdata/ready out.
- Arbitration is round-robin by default. One memory transaction is in flight at a time, and it runs to completion once granted.

---
 rtl/l2_mem_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/l2_mem_arbiter.sv
// l2_mem_arbiter: shares one line-wide memory port between the instruction-side
// (I) and data-side (D) L2 caches. One transaction in flight at a time, granted
// round-robin (or D-first when FIXED_D_PRIO is set) and run to completion.
module l2_mem_arbiter #(
  parameter int ADDR_W       = 28,
  parameter int DATA_W       = 128,
  parameter bit FIXED_D_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state, state_nxt;
  logic              grant, grant_nxt;   // 0 = I, 1 = D
  logic              last, last_nxt;     // last port served
  logic              mem_read_nxt, mem_write_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;

  req_t req_i, req_d, win;
  logic i_req, d_req, pick_d;

  assign req_i = '{rd: i_read, wr: i_write, addr: i_addr, wdata: i_wdata};
  assign req_d = '{rd: d_read, wr: d_write, addr: d_addr, wdata: d_wdata};
  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;

  // Winner select: on contention either D always, or whichever port was not served last
  always_comb begin
    pick_d = d_req;
    if (i_req && d_req) pick_d = FIXED_D_PRIO ? 1'b1 : ~last;
    win = pick_d ? req_d : req_i;
  end

  // Next-state and registered memory-side outputs; everything holds by default
  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    last_nxt      = last;
    mem_read_nxt  = mem_read;
    mem_write_nxt = mem_write;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    case (state)
      S_IDLE: begin
        if (i_req || d_req) begin
          state_nxt     = S_BUSY;
          grant_nxt     = pick_d;
          // a port asserting both read and write is treated as a write
          mem_write_nxt = win.wr;
          mem_read_nxt  = win.rd & ~win.wr;
          mem_addr_nxt  = win.addr;
          mem_wdata_nxt = win.wdata;
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          state_nxt     = S_IDLE;
          last_nxt      = grant;
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and memory-port registers; reset abandons any in-flight access
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state     <= S_IDLE;
      grant     <= 1'b0;
      last      <= 1'b1;   // so I wins the first contention
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      last      <= last_nxt;
      mem_read  <= mem_read_nxt;
      mem_write <= mem_write_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
    end
  end

  // Completion is passed straight through to the granted port only
  assign i_ready = mem_ready & (state == S_BUSY) & ~grant;
  assign d_ready = mem_ready & (state == S_BUSY) &  grant;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule
